serial_receiver_cfg: RTL

Configurable asynchronous serial receiver for the UART path. It is the successor of the fixed 8N1 receiver and adds the following:
- data width of 5..9 bits
- optional odd/even parity
- 1 or 2 stop bits
- start-bit glitch rejection
- separate parity, framing and break reporting

It sits between the external RXD pin and byte-level consumers such as the command parser and FIFOs.

---
 rtl/serial_receiver_cfg.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/serial_receiver_cfg.sv
// Configurable asynchronous serial receiver: 5..9 data bits, optional parity, 1 or 2 stop bits,
// start-bit glitch rejection and separate parity / framing / break reporting.
module serial_receiver_cfg #(
  parameter int pClockFrequency = 16000000,
  parameter int pBaudRate       = 115200,
  parameter int pDataBits       = 8,
  parameter int pParity         = 0,
  parameter int pStopBits       = 1
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iRxd,
  output logic [pDataBits-1:0] oData,
  output logic                 oReceived,
  output logic                 oParityError,
  output logic                 oFrameError,
  output logic                 oBreak,
  output logic                 oBusy
);

  localparam int cT      = pClockFrequency / pBaudRate;
  localparam int cTimerW = $clog2(cT + cT / 2);
  localparam logic [cTimerW-1:0] cHalfLoad = cTimerW'(cT / 2 - 1);
  localparam logic [cTimerW-1:0] cBitLoad  = cTimerW'(cT - 1);

  if (cT < 4 || pDataBits < 5 || pDataBits > 9 || pParity < 0 || pParity > 2 ||
      pStopBits < 1 || pStopBits > 2) begin : g_bad_params
    $fatal(1, "serial_receiver_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {
    stErrorRecovery,
    stIdle,
    stStart,
    stData,
    stParity,
    stStop,
    stResolve
  } state_t;

  state_t                 r_state;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [cTimerW-1:0]     r_timer;
  logic [3:0]             r_bit_cnt;
  logic                   r_stop_cnt;
  logic [pDataBits-1:0]   r_shift;
  logic                   r_parity_ok;
  logic                   r_all_zero;
  logic                   r_stop_fail;

  logic w_rxd_s;
  logic w_tick;
  logic w_par_exp;

  assign w_rxd_s   = r_sync2;
  assign w_tick    = (r_timer == '0);
  // Even parity bit equals the data XOR; odd parity inverts it.
  assign w_par_exp = (^r_shift) ^ (pParity == 1);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state      <= stErrorRecovery;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_parity_ok  <= 1'b0;
      r_all_zero   <= 1'b0;
      r_stop_fail  <= 1'b0;
      oData        <= '0;
      oReceived    <= 1'b0;
      oParityError <= 1'b0;
      oFrameError  <= 1'b0;
      oBreak       <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      r_sync1      <= iRxd;
      r_sync2      <= r_sync1;
      oReceived    <= 1'b0;
      oParityError <= 1'b0;
      oFrameError  <= 1'b0;
      oBreak       <= 1'b0;

      case (r_state)
        stErrorRecovery: begin
          oBusy <= 1'b0;
          if (w_rxd_s) r_state <= stIdle;
        end

        stIdle: begin
          if (!w_rxd_s) begin
            r_state <= stStart;
            r_timer <= cHalfLoad;
            oBusy   <= 1'b1;
          end
        end

        stStart: begin
          if (!w_tick) begin
            r_timer <= r_timer - 1'b1;
          end else if (w_rxd_s) begin
            r_state <= stIdle;
            oBusy   <= 1'b0;
          end else begin
            r_state     <= stData;
            r_timer     <= cBitLoad;
            r_bit_cnt   <= '0;
            r_all_zero  <= 1'b1;
            r_parity_ok <= 1'b1;
            r_stop_fail <= 1'b0;
          end
        end

        stData: begin
          if (!w_tick) begin
            r_timer <= r_timer - 1'b1;
          end else begin
            r_shift <= {w_rxd_s, r_shift[pDataBits-1:1]};
            r_timer <= cBitLoad;
            if (w_rxd_s) r_all_zero <= 1'b0;
            if (r_bit_cnt == 4'(pDataBits - 1)) begin
              r_state    <= (pParity != 0) ? stParity : stStop;
              r_stop_cnt <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        stParity: begin
          if (!w_tick) begin
            r_timer <= r_timer - 1'b1;
          end else begin
            r_parity_ok <= (w_rxd_s == w_par_exp);
            if (w_rxd_s) r_all_zero <= 1'b0;
            r_timer    <= cBitLoad;
            r_stop_cnt <= 1'b0;
            r_state    <= stStop;
          end
        end

        // A low stop sample decides the frame at once; later stop bits are ignored.
        stStop: begin
          if (!w_tick) begin
            r_timer <= r_timer - 1'b1;
          end else if (!w_rxd_s) begin
            r_stop_fail <= 1'b1;
            r_state     <= stResolve;
          end else if (r_stop_cnt == 1'(pStopBits - 1)) begin
            r_state <= stResolve;
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
            r_timer    <= cBitLoad;
          end
        end

        stResolve: begin
          oBusy <= 1'b0;
          if (r_stop_fail) begin
            if (r_all_zero) begin
              oBreak <= 1'b1;
            end else begin
              oFrameError <= 1'b1;
              oData       <= r_shift;
            end
            r_state <= stErrorRecovery;
          end else begin
            oData <= r_shift;
            if (r_parity_ok) oReceived <= 1'b1;
            else             oParityError <= 1'b1;
            r_state <= stIdle;
          end
        end

        default: begin
          r_state <= stErrorRecovery;
          oBusy   <= 1'b0;
`ifdef Simulation
          $display("serial_receiver_cfg: illegal state %0d", r_state);
          $stop;
`endif
        end
      endcase
    end
  end

endmodule
